// File: rtl/parking_gate_arbiter_pkg.sv
// Shared encodings for the parking gate arbiter: FSM states, service direction
// and the width of the occupancy count read back from the counter.
package parking_gate_arbiter_pkg;

  localparam int CNT_W = 3;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_OPENING  = 3'd1;
  localparam logic [2:0] ST_WAIT_CAR = 3'd2;
  localparam logic [2:0] ST_PASSING  = 3'd3;
  localparam logic [2:0] ST_CLOSING  = 3'd4;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    OPENING  = ST_OPENING,
    WAIT_CAR = ST_WAIT_CAR,
    PASSING  = ST_PASSING,
    CLOSING  = ST_CLOSING
  } state_t;

  // Timer must reach the larger of the two terminal counts without wrapping.
  function automatic int timer_width(int a, int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Up-counter with synchronous clear and a terminal-count compare, used to time
// the barrier motor phases and the wait-for-car window.
module gate_timer
  import parking_gate_arbiter_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         at_term
);

  logic [W-1:0] value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (en) begin
      value <= value + 1'b1;
    end
  end

  assign at_term = (value == term);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Single-lane barrier controller: arbitrates entry/exit requests, sequences the
// motor and emits the one-cycle z1/z2 completion pulses to the occupancy counter.
module parking_gate_arbiter
  import parking_gate_arbiter_pkg::*;
#(
  parameter int OPEN_TICKS   = 4,
  parameter int PASS_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             pass_sensor,
  input  logic             lleno,
  input  logic [CNT_W-1:0] count,
  output logic             motor_up,
  output logic             motor_down,
  output logic             busy,
  output logic             dir,
  output logic             z1,
  output logic             z2,
  output logic             timeout_err
);

  localparam int TW = timer_width(OPEN_TICKS, PASS_TIMEOUT);

  state_t        state;
  state_t        state_nxt;
  logic          last_served;
  logic          ent_ok;
  logic          ext_ok;
  logic          grant;
  logic          do_grant;
  logic          z1_nxt;
  logic          z2_nxt;
  logic          to_nxt;
  logic          timer_clr;
  logic          timer_en;
  logic          at_term;
  logic [TW-1:0] term;

  assign ent_ok = req_in & ~lleno;
  assign ext_ok = req_out & (count != '0);
  assign term   = (state == WAIT_CAR) ? TW'(PASS_TIMEOUT - 1) : TW'(OPEN_TICKS - 1);

  gate_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clr),
    .en      (timer_en),
    .term    (term),
    .at_term (at_term)
  );

  always_comb begin
    state_nxt = state;
    do_grant  = 1'b0;
    z1_nxt    = 1'b0;
    z2_nxt    = 1'b0;
    to_nxt    = 1'b0;
    timer_clr = 1'b1;
    timer_en  = 1'b0;
    // Contention: a full lot always favours exit, otherwise alternate.
    if (ent_ok && ext_ok) begin
      grant = lleno ? DIR_OUT : ~last_served;
    end else if (ent_ok) begin
      grant = DIR_IN;
    end else begin
      grant = DIR_OUT;
    end
    case (state)
      IDLE: begin
        if (ent_ok || ext_ok) begin
          do_grant  = 1'b1;
          state_nxt = OPENING;
        end
      end
      OPENING: begin
        if (at_term) begin
          state_nxt = WAIT_CAR;
        end else begin
          timer_clr = 1'b0;
          timer_en  = 1'b1;
        end
      end
      WAIT_CAR: begin
        if (pass_sensor) begin
          state_nxt = PASSING;
        end else if (at_term) begin
          state_nxt = CLOSING;
          to_nxt    = 1'b1;
        end else begin
          timer_clr = 1'b0;
          timer_en  = 1'b1;
        end
      end
      PASSING: begin
        if (!pass_sensor) begin
          state_nxt = CLOSING;
          z1_nxt    = (dir == DIR_IN);
          z2_nxt    = (dir == DIR_OUT);
        end
      end
      CLOSING: begin
        // Something under the barrier while lowering: reopen for safety.
        if (pass_sensor) begin
          state_nxt = OPENING;
        end else if (at_term) begin
          state_nxt = IDLE;
        end else begin
          timer_clr = 1'b0;
          timer_en  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dir         <= DIR_IN;
      last_served <= DIR_OUT;
      motor_up    <= 1'b0;
      motor_down  <= 1'b0;
      busy        <= 1'b0;
      z1          <= 1'b0;
      z2          <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        dir         <= grant;
        last_served <= grant;
      end
      motor_up    <= (state_nxt == OPENING);
      motor_down  <= (state_nxt == CLOSING);
      busy        <= (state_nxt != IDLE);
      z1          <= z1_nxt;
      z2          <= z2_nxt;
      timeout_err <= to_nxt;
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Randomized bench for parking_gate_arbiter against a phase/countdown model of
// the gate service, including asynchronous resets mid-operation.
module tb_parking_gate_arbiter;

  localparam int OPEN_TICKS   = 4;
  localparam int PASS_TIMEOUT = 16;

  localparam int PH_IDLE  = 0;
  localparam int PH_OPEN  = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_PASS  = 3;
  localparam int PH_CLOSE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_in = 1'b0;
  logic       req_out = 1'b0;
  logic       pass_sensor = 1'b0;
  logic       lleno = 1'b0;
  logic [2:0] count = 3'd0;
  logic       motor_up, motor_down, busy, dir, z1, z2, timeout_err;

  int n_chk = 0;
  int n_pass = 0;

  int   m_phase;
  int   m_left;
  logic m_dir, m_last, m_z1, m_z2, m_to;

  parking_gate_arbiter #(.OPEN_TICKS(OPEN_TICKS), .PASS_TIMEOUT(PASS_TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_in      (req_in),
    .req_out     (req_out),
    .pass_sensor (pass_sensor),
    .lleno       (lleno),
    .count       (count),
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .busy        (busy),
    .dir         (dir),
    .z1          (z1),
    .z2          (z2),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] obs();
    return {25'd0, motor_up, motor_down, busy, dir, z1, z2, timeout_err};
  endfunction

  function automatic logic [31:0] expv();
    return {25'd0, m_phase == PH_OPEN, m_phase == PH_CLOSE, m_phase != PH_IDLE,
            m_dir, m_z1, m_z2, m_to};
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_left = 0;
    m_dir = 1'b0; m_last = 1'b1;
    m_z1 = 1'b0; m_z2 = 1'b0; m_to = 1'b0;
  endtask

  // One clock of gate service, expressed as phases with remaining-cycle budgets.
  task automatic model_step();
    bit ent, ext, g;
    m_z1 = 1'b0; m_z2 = 1'b0; m_to = 1'b0;
    case (m_phase)
      PH_IDLE: begin
        ent = req_in && !lleno;
        ext = req_out && (count != 0);
        if (ent || ext) begin
          if (ent && ext) g = lleno ? 1'b1 : !m_last;
          else g = ext;
          m_dir = g; m_last = g;
          m_phase = PH_OPEN; m_left = OPEN_TICKS;
        end
      end
      PH_OPEN: begin
        m_left--;
        if (m_left == 0) begin m_phase = PH_WAIT; m_left = PASS_TIMEOUT; end
      end
      PH_WAIT: begin
        if (pass_sensor) m_phase = PH_PASS;
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = PH_CLOSE; m_left = OPEN_TICKS; m_to = 1'b1; end
        end
      end
      PH_PASS: begin
        if (!pass_sensor) begin
          m_phase = PH_CLOSE; m_left = OPEN_TICKS;
          if (m_dir) m_z2 = 1'b1; else m_z1 = 1'b1;
        end
      end
      default: begin
        if (pass_sensor) begin m_phase = PH_OPEN; m_left = OPEN_TICKS; end
        else begin
          m_left--;
          if (m_left == 0) m_phase = PH_IDLE;
        end
      end
    endcase
  endtask

  initial begin
    int pass_pct, req_pct, mode;
    bit hold_both;
    model_reset();
    #12;
    check("reset_outputs", obs(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int seg = 0; seg < 40; seg++) begin
      mode = $urandom_range(3);
      if (seg == 0) begin pass_pct = 0; lleno = 1'b0; count = 3'd3; hold_both = 0; end
      else if (seg == 1) begin pass_pct = 40; lleno = 1'b0; count = 3'd3; hold_both = 1; end
      else if (seg == 2) begin pass_pct = 40; lleno = 1'b1; count = 3'd7; hold_both = 1; end
      else begin
        case ($urandom_range(3))
          0: pass_pct = 0;
          1: pass_pct = 15;
          2: pass_pct = 50;
          default: pass_pct = 85;
        endcase
        hold_both = ($urandom_range(3) == 0);
        if (mode == 0) begin lleno = 1'b1; count = 3'd7; end
        else if (mode == 1) begin lleno = 1'b0; count = 3'd0; end
        else begin lleno = 1'b0; count = 3'($urandom_range(6, 1)); end
      end
      req_pct = 40;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
        check($sformatf("outputs seg%0d cyc%0d", seg, c), obs(), expv());
        if (reset) begin
          reset = 1'b0;
        end else begin
          req_in  = hold_both ? 1'b1 : ($urandom_range(99) < req_pct);
          req_out = hold_both ? 1'b1 : ($urandom_range(99) < req_pct);
          pass_sensor = ($urandom_range(99) < pass_pct);
          if (seg > 2 && $urandom_range(99) < 2) begin
            #2 reset = 1'b1;
            model_reset();
            #1 check("async_reset", obs(), 32'd0);
          end
        end
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
